// File: rtl/sss_pkg.sv
// Shared constants and FSM state type for the SSS search controller.
// No ports; imported by sss_search_ctrl and sc_window_counter.
package sss_pkg;

   localparam int SSS_LEN    = 127;
   localparam int N_id_1_MAX = 335;
   localparam int N_id_MAX   = 1007;

   typedef enum logic [2:0] {
      IDLE,
      SKIP,
      FEED,
      WAIT_RES,
      FLUSH
   } state_t;

endpackage

// File: rtl/sc_window_counter.sv
// Subcarrier beat counter for the FFT output stream.
// Ports:
//   clk_i, reset_i   clock, async active-high reset
//   clr_i            synchronous clear to subcarrier 0
//   beat_i           a valid beat is being counted this cycle
//   last_i           tlast of the beat
//   sym_end_o        this beat closes the symbol (tlast or last index)
//   in_win_o         current subcarrier lies in [WIN_START, WIN_START+WIN_LEN)
module sc_window_counter
   import sss_pkg::*;
#(
   parameter int SC_PER_SYM = 240,
   parameter int WIN_START  = 56,
   parameter int WIN_LEN    = SSS_LEN
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clr_i,
   input  logic beat_i,
   input  logic last_i,
   output logic sym_end_o,
   output logic in_win_o
);

   localparam int CW = $clog2(SC_PER_SYM);

   logic [CW-1:0] sc_cnt;
   logic [31:0]   sc_ext;

   assign sc_ext    = 32'(sc_cnt);
   assign sym_end_o = beat_i && (last_i || (sc_cnt == CW'(SC_PER_SYM - 1)));
   assign in_win_o  = (sc_ext >= 32'(WIN_START)) && (sc_ext < 32'(WIN_START + WIN_LEN));

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sc_cnt <= '0;
      end else if (clr_i || sym_end_o) begin
         sc_cnt <= '0;
      end else if (beat_i) begin
         sc_cnt <= sc_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sss_search_ctrl.sv
// SSS search sequencer: one search per PSS hit. Latches N_id_2, skips whole
// symbols, forwards the 127 SSS subcarriers to the SSS detector, then waits
// for the detector result under a timeout and publishes the cell ID.
// Ports:
//   clk_i, reset_i                       clock, async active-high reset
//   N_id_2_i, N_id_2_valid_i             PSS detector hit
//   s_axis_in_tdata/tvalid/tlast         FFT output subcarrier stream
//   sss_tdata_o, sss_tvalid_o            subcarriers to SSS detector (1-cycle latency)
//   det_N_id_2_o, det_N_id_2_valid_o     latched N_id_2 and strobe to detector
//   det_N_id_i, det_N_id_valid_i         detector result
//   det_rst_o                            detector reset request
//   N_id_o, N_id_valid_o                 published cell ID and strobe
//   timeout_o                            search aborted strobe
//   busy_o                               search in progress
//
// state    | meaning
// IDLE     | waiting for a PSS hit
// SKIP     | discarding SYM_SKIP whole symbols
// FEED     | forwarding the SSS window of the current symbol
// WAIT_RES | waiting for the detector result, timeout running
// FLUSH    | holding detector reset for two cycles after an abort
module sss_search_ctrl
   import sss_pkg::*;
#(
   parameter int IN_DW        = 16,
   parameter int SC_PER_SYM   = 240,
   parameter int SSS_SC_START = 56,
   parameter int SYM_SKIP     = 1,
   parameter int TIMEOUT_CYC  = 65535
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [1:0]       N_id_2_i,
   input  logic             N_id_2_valid_i,
   input  logic [IN_DW-1:0] s_axis_in_tdata,
   input  logic             s_axis_in_tvalid,
   input  logic             s_axis_in_tlast,
   output logic [IN_DW-1:0] sss_tdata_o,
   output logic             sss_tvalid_o,
   output logic [1:0]       det_N_id_2_o,
   output logic             det_N_id_2_valid_o,
   input  logic [9:0]       det_N_id_i,
   input  logic             det_N_id_valid_i,
   output logic             det_rst_o,
   output logic [9:0]       N_id_o,
   output logic             N_id_valid_o,
   output logic             timeout_o,
   output logic             busy_o
);

   localparam int SYW = (SYM_SKIP > 0) ? $clog2(SYM_SKIP + 1) : 1;
   localparam int TOW = $clog2(TIMEOUT_CYC + 1);

   state_t         state, state_nxt;
   logic [SYW-1:0] sym_cnt;
   logic [7:0]     feed_cnt;
   logic [TOW-1:0] to_cnt;
   logic           fl_cnt;

   logic beat, sym_end, in_win;
   logic pss_take, res_take, to_hit, sym_done, fwd, last_fwd, fault;

   sc_window_counter #(
      .SC_PER_SYM (SC_PER_SYM),
      .WIN_START  (SSS_SC_START),
      .WIN_LEN    (SSS_LEN)
   ) u_sc_cnt (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clr_i     (state == IDLE),
      .beat_i    (beat),
      .last_i    (s_axis_in_tlast),
      .sym_end_o (sym_end),
      .in_win_o  (in_win)
   );

   always_comb begin
      state_nxt = state;
      beat      = s_axis_in_tvalid && ((state == SKIP) || (state == FEED));
      pss_take  = (state == IDLE) && N_id_2_valid_i;
      res_take  = (state == WAIT_RES) && det_N_id_valid_i;
      // a result arriving on the last allowed cycle beats the timeout
      to_hit    = (state == WAIT_RES) && !det_N_id_valid_i &&
                  (32'(to_cnt) == 32'(TIMEOUT_CYC - 1));
      sym_done  = (state == SKIP) && sym_end && (32'(sym_cnt) == 32'(SYM_SKIP - 1));
      fwd       = (state == FEED) && s_axis_in_tvalid && in_win;
      last_fwd  = fwd && (feed_cnt == 8'(SSS_LEN - 1));
      // tlast on the final forwarded beat is a clean symbol end, not a fault
      fault     = (state == FEED) && s_axis_in_tvalid && s_axis_in_tlast && !last_fwd;

      case (state)
         IDLE:     if (pss_take) state_nxt = (SYM_SKIP == 0) ? FEED : SKIP;
         SKIP:     if (sym_done) state_nxt = FEED;
         FEED: begin
            if (last_fwd)   state_nxt = WAIT_RES;
            else if (fault) state_nxt = FLUSH;
         end
         WAIT_RES: begin
            if (res_take)    state_nxt = IDLE;
            else if (to_hit) state_nxt = FLUSH;
         end
         FLUSH:    if (fl_cnt) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state              <= IDLE;
         sym_cnt            <= '0;
         feed_cnt           <= '0;
         to_cnt             <= '0;
         fl_cnt             <= 1'b0;
         sss_tdata_o        <= '0;
         sss_tvalid_o       <= 1'b0;
         det_N_id_2_o       <= '0;
         det_N_id_2_valid_o <= 1'b0;
         det_rst_o          <= 1'b1;
         N_id_o             <= '0;
         N_id_valid_o       <= 1'b0;
         timeout_o          <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state != SKIP)  sym_cnt <= '0;
         else if (sym_end)   sym_cnt <= sym_cnt + 1'b1;

         if (state != FEED)  feed_cnt <= '0;
         else if (fwd)       feed_cnt <= feed_cnt + 1'b1;

         to_cnt <= (state == WAIT_RES) ? to_cnt + 1'b1 : '0;
         fl_cnt <= (state == FLUSH) && !fl_cnt;

         sss_tvalid_o <= fwd;
         if (fwd) sss_tdata_o <= s_axis_in_tdata;

         det_N_id_2_valid_o <= pss_take;
         if (pss_take) det_N_id_2_o <= N_id_2_i;

         N_id_valid_o <= res_take;
         if (res_take) N_id_o <= det_N_id_i;

         timeout_o <= fault || to_hit;
         det_rst_o <= (state_nxt == FLUSH);
      end
   end

   assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_sss_search_ctrl.sv
module tb_sss_search_ctrl;

   localparam int IN_DW = 16;
   localparam int SC    = 240;
   localparam int START = 56;
   localparam int SKIP  = 1;
   localparam int TMO   = 3000;

   logic             clk_i = 1'b0;
   logic             reset_i;
   logic [1:0]       N_id_2_i;
   logic             N_id_2_valid_i;
   logic [IN_DW-1:0] s_axis_in_tdata;
   logic             s_axis_in_tvalid;
   logic             s_axis_in_tlast;
   logic [IN_DW-1:0] sss_tdata_o;
   logic             sss_tvalid_o;
   logic [1:0]       det_N_id_2_o;
   logic             det_N_id_2_valid_o;
   logic [9:0]       det_N_id_i;
   logic             det_N_id_valid_i;
   logic             det_rst_o;
   logic [9:0]       N_id_o;
   logic             N_id_valid_o;
   logic             timeout_o;
   logic             busy_o;

   always #5 clk_i = ~clk_i;

   sss_search_ctrl #(
      .IN_DW(IN_DW), .SC_PER_SYM(SC), .SSS_SC_START(START),
      .SYM_SKIP(SKIP), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .N_id_2_i(N_id_2_i), .N_id_2_valid_i(N_id_2_valid_i),
      .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tvalid(s_axis_in_tvalid),
      .s_axis_in_tlast(s_axis_in_tlast),
      .sss_tdata_o(sss_tdata_o), .sss_tvalid_o(sss_tvalid_o),
      .det_N_id_2_o(det_N_id_2_o), .det_N_id_2_valid_o(det_N_id_2_valid_o),
      .det_N_id_i(det_N_id_i), .det_N_id_valid_i(det_N_id_valid_i),
      .det_rst_o(det_rst_o), .N_id_o(N_id_o), .N_id_valid_o(N_id_valid_o),
      .timeout_o(timeout_o), .busy_o(busy_o)
   );

   typedef struct {
      int n_id_2;
      int gap_pct;
      int trunc_sc;   // tlast position inside the SSS symbol, -1 none
      int pss2_sc;    // second PSS strobe position inside the SSS symbol, -1 none
      int ans_delay;  // >=0 cycles after stream end, -1 no answer, -2 on the timeout cycle
      int n_id;
      int exp_fwd;
      int exp_idv;
      int exp_to;
   } vec_t;

   vec_t vecs[8];

   int n_checks = 0;
   int n_fail   = 0;
   logic [IN_DW-1:0] got_q[$];
   logic [IN_DW-1:0] exp_q[$];
   int cyc = 0;
   int n_idv, n_to, n_n2v, n_drst, last_fwd_cyc, to_cyc;

   always @(negedge clk_i) begin
      cyc++;
      if (sss_tvalid_o) begin
         got_q.push_back(sss_tdata_o);
         last_fwd_cyc = cyc;
      end
      if (N_id_valid_o)       n_idv++;
      if (timeout_o) begin
         n_to++;
         to_cyc = cyc;
      end
      if (det_N_id_2_valid_o) n_n2v++;
      if (det_rst_o)          n_drst++;
   end

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic clear_stats();
      got_q.delete();
      exp_q.delete();
      n_idv = 0; n_to = 0; n_n2v = 0; n_drst = 0;
      last_fwd_cyc = 0; to_cyc = 0;
   endtask

   task automatic strobe(input int n2);
      tick();
      N_id_2_i       = 2'(n2);
      N_id_2_valid_i = 1'b1;
      tick();
      N_id_2_valid_i = 1'b0;
   endtask

   task automatic pulse_det(input int nid);
      det_N_id_i       = 10'(nid);
      det_N_id_valid_i = 1'b1;
      tick();
      det_N_id_valid_i = 1'b0;
   endtask

   // Drives symbol 0 (skipped) and symbol 1 (SSS) and records the
   // expected forwarded samples: SSS symbol beats in [START, START+126].
   task automatic drive(input int gap_pct, input int trunc_sc, input int pss2_sc, input int stop_sc);
      bit fin = 1'b0;
      for (int s = 0; s < 2 && !fin; s++) begin
         for (int sc = 0; sc < SC && !fin; sc++) begin
            if (s == 1 && sc == stop_sc) begin
               fin = 1'b1;
            end else begin
               while ($urandom_range(99) < gap_pct) begin
                  tick();
                  s_axis_in_tvalid = 1'b0;
                  s_axis_in_tlast  = 1'($urandom_range(1));
                  s_axis_in_tdata  = 16'($urandom);
                  N_id_2_valid_i   = 1'b0;
               end
               tick();
               s_axis_in_tvalid = 1'b1;
               s_axis_in_tdata  = 16'($urandom);
               s_axis_in_tlast  = (sc == SC - 1) || (s == 1 && sc == trunc_sc);
               N_id_2_valid_i   = (s == 1 && sc == pss2_sc);
               N_id_2_i         = N_id_2_valid_i ? 2'd2 : 2'd3;
               if (s == SKIP && sc >= START && sc <= START + 126)
                  exp_q.push_back(s_axis_in_tdata);
               if (s == 1 && sc == trunc_sc) fin = 1'b1;
            end
         end
      end
      tick();
      s_axis_in_tvalid = 1'b0;
      s_axis_in_tlast  = 1'b0;
      N_id_2_valid_i   = 1'b0;
   endtask

   task automatic run_case(input vec_t v, input int idx);
      int errs;
      clear_stats();
      strobe(v.n_id_2);
      drive(v.gap_pct, v.trunc_sc, v.pss2_sc, -1);
      if (v.ans_delay >= 0) begin
         repeat (v.ans_delay) tick();
         pulse_det(v.n_id);
      end else if (v.ans_delay == -2) begin
         for (int i = 0; i < TMO + 100; i++) begin
            if (cyc == last_fwd_cyc + TMO - 1) break;
            tick();
         end
         pulse_det(v.n_id);
      end else begin
         for (int i = 0; i < TMO + 100; i++) begin
            if (n_to != 0) break;
            tick();
         end
      end
      repeat (4) tick();

      errs = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) errs++;
      check($sformatf("case%0d fwd_count", idx), got_q.size(), v.exp_fwd);
      check($sformatf("case%0d model_count", idx), got_q.size(), exp_q.size());
      check($sformatf("case%0d fwd_data_errs", idx), errs, 0);
      check($sformatf("case%0d n2_strobes", idx), n_n2v, 1);
      check($sformatf("case%0d det_N_id_2", idx), int'(det_N_id_2_o), v.n_id_2);
      check($sformatf("case%0d N_id_valid", idx), n_idv, v.exp_idv);
      check($sformatf("case%0d timeout", idx), n_to, v.exp_to);
      if (v.exp_idv != 0)
         check($sformatf("case%0d N_id", idx), int'(N_id_o), v.n_id);
      check($sformatf("case%0d det_rst_cycles", idx), n_drst, (v.exp_to != 0) ? 2 : 0);
      check($sformatf("case%0d busy_after", idx), int'(busy_o), 0);
      if (v.exp_to != 0 && v.trunc_sc < 0)
         check($sformatf("case%0d timeout_cycle", idx), to_cyc - last_fwd_cyc, TMO);
   endtask

   initial begin
      #(1_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1, 0,  -1,  -1, 2000, 'h1F4, 127, 1, 0};
      vecs[1] = '{1, 0,  -1,  -1, -1,   0,     127, 0, 1};
      vecs[2] = '{1, 0,  -1,  100, 50,  'h2A,  127, 1, 0};
      vecs[3] = '{int'($urandom_range(2)), 50, -1, -1, 10, int'($urandom_range(1007)), 127, 1, 0};
      vecs[4] = '{2, 0,  100, -1, -1,   0,     45,  0, 1};
      vecs[5] = '{int'($urandom_range(2)), 50, 182, -1, 5, int'($urandom_range(1007)), 127, 1, 0};
      vecs[6] = '{1, 30, 55,  -1, -1,   0,     0,   0, 1};
      vecs[7] = '{0, 0,  -1,  -1, -2,   'h3EF, 127, 1, 0};

      reset_i          = 1'b1;
      N_id_2_i         = '0;
      N_id_2_valid_i   = 1'b0;
      s_axis_in_tdata  = '0;
      s_axis_in_tvalid = 1'b0;
      s_axis_in_tlast  = 1'b0;
      det_N_id_i       = '0;
      det_N_id_valid_i = 1'b0;
      #1;
      check("reset det_rst", int'(det_rst_o), 1);
      check("reset busy", int'(busy_o), 0);
      check("reset sss_tvalid", int'(sss_tvalid_o), 0);
      check("reset N_id_valid", int'(N_id_valid_o), 0);
      check("reset timeout", int'(timeout_o), 0);
      check("reset n2_valid", int'(det_N_id_2_valid_o), 0);
      repeat (3) tick();
      reset_i = 1'b0;
      check("release det_rst held", int'(det_rst_o), 1);
      tick();
      check("release det_rst drop", int'(det_rst_o), 0);

      clear_stats();
      pulse_det(77);
      repeat (2) tick();
      check("idle det ignored", n_idv, 0);
      check("idle N_id unchanged", int'(N_id_o), 0);

      for (int i = 0; i < 8; i++) run_case(vecs[i], i);

      clear_stats();
      strobe(1);
      drive(0, -1, -1, 120);
      reset_i = 1'b1;
      #1;
      check("midfeed det_rst", int'(det_rst_o), 1);
      check("midfeed busy", int'(busy_o), 0);
      check("midfeed sss_tvalid", int'(sss_tvalid_o), 0);
      check("midfeed N_id", int'(N_id_o), 0);
      check("midfeed det_N_id_2", int'(det_N_id_2_o), 0);
      tick();
      reset_i = 1'b0;
      repeat (3) tick();
      check("midfeed no result", n_idv + n_to, 0);
      run_case(vecs[0], 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
